// File: rtl/line_follow_controller.sv
// line_follow_controller: weighted line-position error drives saturated differential wheel commands
// Ports: clk; reset (async, active-low); enable (0 forces IDLE); sensors (bit N-1 leftmost);
//   speed (unsigned base speed); wheel_left/wheel_right (signed, registered);
//   state (IDLE=0 TRACK=1 CROSS=2 LOST=3 STOP=4).
// Build option: define RAMP_EN to slew-limit the wheel outputs by RAMP_STEP per cycle.
module line_follow_controller #(
  parameter int NUM_SENSORS  = 4,
  parameter int SPEED_W      = 6,
  parameter int WHEEL_W      = 8,
  parameter int TURN_GAIN    = 4,
  parameter int SEARCH_SPEED = 16,
  parameter int LOST_TIMEOUT = 1000,
  parameter int RAMP_STEP    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_SENSORS-1:0]    sensors,
  input  logic [SPEED_W-1:0]        speed,
  output logic signed [WHEEL_W-1:0] wheel_left,
  output logic signed [WHEEL_W-1:0] wheel_right,
  output logic [2:0]                state
);
  typedef enum logic [2:0] {IDLE = 3'd0, TRACK = 3'd1, CROSS = 3'd2, LOST = 3'd3, STOP = 3'd4} state_t;
`ifdef RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif
  localparam int CW = LOST_TIMEOUT > 1 ? $clog2(LOST_TIMEOUT) : 1;
  localparam logic signed [31:0] W_MAX = 2 ** (WHEEL_W - 1) - 1;
  localparam logic signed [31:0] W_MIN = -(2 ** (WHEEL_W - 1));
  localparam logic signed [WHEEL_W-1:0] SS = WHEEL_W'(SEARCH_SPEED);
  localparam logic signed [WHEEL_W-1:0] RS = WHEEL_W'(RAMP_STEP);
  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      dir_q, dir_d;
  logic signed [WHEEL_W-1:0] wl_q, wl_d, wr_q, wr_d, tl, tr;
  logic signed [31:0]        err, turn, spd;
  function automatic logic signed [WHEEL_W-1:0] sat(input logic signed [31:0] v);
    return v > W_MAX ? W_MAX[WHEEL_W-1:0] : v < W_MIN ? W_MIN[WHEEL_W-1:0] : v[WHEEL_W-1:0];
  endfunction
  function automatic logic signed [WHEEL_W-1:0] slew(input logic signed [WHEEL_W-1:0] q,
                                                     input logic signed [WHEEL_W-1:0] t);
    logic signed [31:0] d;
    d = 32'(t) - 32'(q);
    return d > RAMP_STEP ? q + RS : d < -RAMP_STEP ? q - RS : t;
  endfunction
  always_comb begin
    err = '0;
    for (int i = 0; i < NUM_SENSORS; i++)
      if (sensors[i]) err = err + 2 * i - (NUM_SENSORS - 1);
    turn = err * TURN_GAIN;
    spd = 32'(speed);
  end
  // Priority: enable, then IDLE exit, then line pattern; an all-zero pattern
  // is the only case that can move LOST toward STOP, so a returning line always wins.
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    dir_d = dir_q;
    tl = '0;
    tr = '0;
    if (!enable) state_d = IDLE;
    else if (state_q == IDLE) state_d = TRACK;
    else if (&sensors) begin
      state_d = CROSS;
      tl = sat(spd);
      tr = sat(spd);
    end else if (|sensors) begin
      state_d = TRACK;
      tl = sat(spd - turn);
      tr = sat(spd + turn);
      dir_d = err > 0 ? 1'b1 : err < 0 ? 1'b0 : dir_q;
    end else if (state_q == TRACK || state_q == CROSS || (state_q == LOST && cnt_q != CW'(LOST_TIMEOUT - 1))) begin
      state_d = LOST;
      cnt_d = state_q == LOST ? cnt_q + 1'b1 : '0;
      tl = dir_q ? -SS : SS;
      tr = dir_q ? SS : -SS;
    end else state_d = STOP;
    wl_d = !enable ? '0 : RAMP ? slew(wl_q, tl) : tl;
    wr_d = !enable ? '0 : RAMP ? slew(wr_q, tr) : tr;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dir_q <= 1'b0;
      wl_q <= '0;
      wr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      wl_q <= wl_d;
      wr_q <= wr_d;
    end
  assign wheel_left = wl_q;
  assign wheel_right = wr_q;
  assign state = state_q;
endmodule

// File: tb/tb_line_follow_controller.sv
// tb_line_follow_controller: table vectors, corner sequences and randomized model check for line_follow_controller
module tb_line_follow_controller;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [3:0] sensors = '0;
  logic [5:0] speed = '0;
  logic signed [7:0] wl[2], wr[2];
  logic [2:0] st[2];
  int total = 0, bad = 0;
  int m_st[2], m_cnt[2], m_wl[2], m_wr[2];
  bit m_dir[2];
  typedef struct {logic [3:0] s; int sp; int wl; int wr; int st;} vec_t;
  vec_t tab[$];
  always #5 clk = ~clk;
  line_follow_controller #(.LOST_TIMEOUT(5)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .sensors(sensors), .speed(speed),
    .wheel_left(wl[0]), .wheel_right(wr[0]), .state(st[0]));
  line_follow_controller #(.TURN_GAIN(32), .LOST_TIMEOUT(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .sensors(sensors), .speed(speed),
    .wheel_left(wl[1]), .wheel_right(wr[1]), .state(st[1]));
  function automatic int gain(input int k); return k ? 32 : 4; endfunction
  function automatic int tmo(input int k); return k ? 1 : 5; endfunction
  function automatic int clip(input int v); return v > 127 ? 127 : v < -128 ? -128 : v; endfunction
  function automatic int ramp(input int q, input int t);
    return t - q > 2 ? q + 2 : t - q < -2 ? q - 2 : t;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_wl[k] = 0; m_wr[k] = 0; m_dir[k] = 0;
    end
  endtask
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int e, sp, tl, tr;
      e = 0; sp = int'(speed); tl = 0; tr = 0;
      for (int i = 0; i < 4; i++) if (sensors[i]) e += 2 * i - 3;
      if (!enable) begin m_st[k] = 0; m_cnt[k] = 0; end
      else if (m_st[k] == 0) m_st[k] = 1;
      else if (sensors == 4'hf) begin m_st[k] = 2; m_cnt[k] = 0; tl = sp; tr = sp; end
      else if (sensors != 0) begin
        m_st[k] = 1; m_cnt[k] = 0;
        tl = clip(sp - e * gain(k)); tr = clip(sp + e * gain(k));
        if (e > 0) m_dir[k] = 1; else if (e < 0) m_dir[k] = 0;
      end else if (m_st[k] == 4 || (m_st[k] == 3 && m_cnt[k] == tmo(k) - 1)) begin
        m_st[k] = 4; m_cnt[k] = 0;
      end else begin
        m_cnt[k] = m_st[k] == 3 ? m_cnt[k] + 1 : 0;
        m_st[k] = 3;
        tl = m_dir[k] ? -16 : 16; tr = -tl;
      end
`ifdef RAMP_EN
      m_wl[k] = enable ? ramp(m_wl[k], tl) : 0;
      m_wr[k] = enable ? ramp(m_wr[k], tr) : 0;
`else
      m_wl[k] = tl; m_wr[k] = tr;
`endif
    end
  endtask
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask
  task automatic check_model(input int k);
    chk($sformatf("model_wl%0d", k), int'(wl[k]), m_wl[k]);
    chk($sformatf("model_wr%0d", k), int'(wr[k]), m_wr[k]);
    chk($sformatf("model_st%0d", k), int'(st[k]), m_st[k]);
  endtask
  task automatic add(input logic [3:0] s, input int sp, input int l, input int r, input int q);
    vec_t v;
    v.s = s; v.sp = sp; v.wl = l; v.wr = r; v.st = q;
    tab.push_back(v);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_model(k);
    chk("reset_st_a", int'(st[0]), 0);
    reset = 1'b1;
    enable = 1'b1; sensors = 4'b0110; speed = 6'd32;
    step();
    chk("idle_to_track", int'(st[0]), 1);
    check_model(0);
    check_model(1);
`ifndef RAMP_EN
    add(4'b0110, 32, 32, 32, 1);
    add(4'b1000, 32, 20, 44, 1);
    add(4'b0001, 32, 44, 20, 1);
    add(4'b1000, 32, 20, 44, 1);
    add(4'b1111, 32, 32, 32, 2);
    add(4'b1100, 10, -6, 26, 1);
    repeat (5) add(4'b0000, 10, -16, 16, 3);
    repeat (2) add(4'b0000, 10, 0, 0, 4);
    add(4'b0100, 32, 28, 36, 1);
    repeat (5) add(4'b0000, 32, -16, 16, 3);
    add(4'b0010, 32, 36, 28, 1);
    add(4'b0010, 32, 36, 28, 1);
    add(4'b0000, 32, 16, -16, 3);
    add(4'b1111, 63, 63, 63, 2);
    add(4'b0000, 63, 16, -16, 3);
    add(4'b1000, 63, 51, 75, 1);
    foreach (tab[n]) begin
      sensors = tab[n].s; speed = 6'(tab[n].sp);
      step();
      chk($sformatf("tab%0d_wl", n), int'(wl[0]), tab[n].wl);
      chk($sformatf("tab%0d_wr", n), int'(wr[0]), tab[n].wr);
      chk($sformatf("tab%0d_st", n), int'(st[0]), tab[n].st);
      check_model(1);
    end
    chk("sat_wl_b", int'(wl[1]), -33);
    chk("sat_wr_b", int'(wr[1]), 127);
    sensors = 4'b1111;
    step();
    chk("cross_wl_b", int'(wl[1]), 63);
    chk("cross_st_b", int'(st[1]), 2);
`endif
    reset = 1'b0;
    #2;
    chk("async_rst_wl", int'(wl[0]), 0);
    chk("async_rst_wr", int'(wr[0]), 0);
    chk("async_rst_st", int'(st[0]), 0);
    model_reset();
    #1 reset = 1'b1;
    sensors = 4'b1000; speed = 6'd63;
    step();
    chk("rst_then_track", int'(st[0]), 1);
    step();
    check_model(0);
    enable = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("dis%0d_st", j), int'(st[0]), 0);
      chk($sformatf("dis%0d_wl", j), int'(wl[0]), 0);
      chk($sformatf("dis%0d_wr", j), int'(wr[0]), 0);
    end
    enable = 1'b1;
    step();
    chk("reenable_st", int'(st[0]), 1);
`ifdef RAMP_EN
    sensors = 4'b0110; speed = 6'd0;
    repeat (40) step();
    speed = 6'd32;
    for (int j = 0; j < 16; j++) begin
      step();
      chk($sformatf("ramp%0d", j), int'(wl[0]), 2 * (j + 1));
    end
    enable = 1'b0;
    step();
    chk("ramp_dis", int'(wl[0]), 0);
    enable = 1'b1;
    step();
`endif
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_model(0);
        check_model(1);
        reset = 1'b1;
      end
      enable = $urandom_range(0, 19) != 0;
      if ($urandom_range(0, 2) == 0) begin
        int r;
        r = $urandom_range(0, 9);
        sensors = r < 4 ? 4'h0 : r == 4 ? 4'hf : 4'($urandom);
        speed = 6'($urandom);
      end
      step();
      check_model(0);
      check_model(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
